// File: rtl/control_pkg.sv
// Shared types and constants for the unidad_control sequencer: state encoding,
// opcode values, flag bit positions and the opcode -> control word table.
package control_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Control word layout: [15] reg write, [14] mem write, [13] mem read,
  // [12] output enable, [11:8] ALU op, [7:0] one-hot operand source select.
  // Flow-control opcodes never reach EXECUTE, so their entries are all zero.
  localparam logic [15:0] CW_TABLE [16] = '{
    16'h8001, 16'h8102, 16'h8204, 16'h8308,
    16'h8410, 16'h8520, 16'h8640, 16'h8780,
    16'h4801, 16'h4902, 16'h2A04, 16'h1B08,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  function automatic logic is_datapath(input logic [3:0] op);
    return op < OP_JC;
  endfunction

endpackage

// File: rtl/decodificador_instr.sv
// Combinational opcode -> datapath control word lookup.
module decodificador_instr
  import control_pkg::*;
(
  input  logic [3:0]  opcode,
  output logic [15:0] control_word
);

  assign control_word = CW_TABLE[opcode];

endmodule

// File: rtl/unidad_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE sequencer with program
// counter, instruction register and flags latched from the last EXECUTE.
module unidad_control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  instr,
  input  logic [3:0]  flags,
  output logic [3:0]  pc_addr,
  output logic [15:0] control,
  output logic [3:0]  constant_out,
  output logic        busy,
  output logic        halted
);

  state_t      state, state_next;
  logic [3:0]  pc, pc_next;
  logic [7:0]  ir;
  logic [3:0]  flag_reg;
  logic [15:0] cw;
  logic [3:0]  opcode, operand, pc_inc;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];
  assign pc_inc  = pc + 4'd1;

  decodificador_instr u_decodificador_instr (
    .opcode       (opcode),
    .control_word (cw)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= 4'h0;
      ir       <= 8'h00;
      flag_reg <= 4'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH)   ir       <= instr;
      if (state == EXECUTE) flag_reg <= flags;
    end
  end

  // NOTE: next-state and next-pc get defaults before the case so no path
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = DECODE;
      DECODE: begin
        if (is_datapath(opcode)) begin
          pc_next    = pc_inc;
          state_next = EXECUTE;
        end else begin
          unique case (opcode)
            OP_JMP: begin
              pc_next    = operand;
              state_next = FETCH;
            end
            OP_JZ: begin
              pc_next    = flag_reg[FLAG_Z] ? operand : pc_inc;
              state_next = FETCH;
            end
            OP_JC: begin
              pc_next    = flag_reg[FLAG_C] ? operand : pc_inc;
              state_next = FETCH;
            end
            default: state_next = HALT;
          endcase
        end
      end
      EXECUTE: state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from registered state and ir only; reset clears
  // them at once because state drops to IDLE asynchronously.
  assign pc_addr      = pc;
  assign control      = (state == EXECUTE) ? cw : 16'h0000;
  assign constant_out = (state == EXECUTE) ? operand : 4'h0;
  assign busy         = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
  assign halted       = (state == HALT);

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: an instruction-level interpreter
// predicts EXECUTE and HALT events with their cycle numbers.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  instr;
  logic [3:0]  flags;
  logic [3:0]  pc_addr;
  logic [15:0] control;
  logic [3:0]  constant_out;
  logic        busy;
  logic        halted;

  logic [7:0]  mem [16];
  logic [3:0]  fl [256];

  localparam logic [15:0] REF_CW [16] = '{
    16'h8001, 16'h8102, 16'h8204, 16'h8308,
    16'h8410, 16'h8520, 16'h8640, 16'h8780,
    16'h4801, 16'h4902, 16'h2A04, 16'h1B08,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  typedef struct {
    bit          is_halt;
    int          cyc;
    logic [3:0]  pc;
    logic [15:0] cw;
    logic [3:0]  k;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   halt_seen = 1'b0;

  unidad_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .instr        (instr),
    .flags        (flags),
    .pc_addr      (pc_addr),
    .control      (control),
    .constant_out (constant_out),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;
  assign instr = mem[pc_addr];

  task automatic check(input bit ok, input string name, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Interpreter: walks the program instruction by instruction, charging
  // 3 cycles per datapath op and 2 per jump/branch/halt decode.
  task automatic build_expect(input int budget, output int end_cyc,
                              output bit will_halt);
    int         c = 1;
    logic [3:0] pc = 4'h0;
    logic [3:0] fr = 4'h0;
    logic [7:0] w;
    int         op;
    bit         done = 0;
    exp_t       e;
    will_halt = 0;
    while (c <= budget && !done) begin
      w  = mem[pc];
      op = int'(w[7:4]);
      if (op < 12) begin
        if (c + 2 <= budget) begin
          e = '{0, c + 2, 4'((int'(pc) + 1) % 16), REF_CW[op], w[3:0]};
          exp_q.push_back(e);
          fr = fl[c + 2];
        end
        pc = 4'((int'(pc) + 1) % 16);
        c += 3;
      end else if (op == 14) begin
        pc = w[3:0];
        c += 2;
      end else if (op == 13 || op == 12) begin
        if (fr[op == 13 ? 0 : 1]) pc = w[3:0];
        else                      pc = 4'((int'(pc) + 1) % 16);
        c += 2;
      end else begin
        if (c + 2 <= budget) begin
          e = '{1, c + 2, pc, 16'h0000, 4'h0};
          exp_q.push_back(e);
          will_halt = 1;
        end
        done = 1;
      end
    end
    end_cyc = will_halt ? c + 5 : budget;
  endtask

  // fixed_flags < 0 means random flags every cycle (live flags are noise
  // except at the edge that closes an EXECUTE).
  task automatic run_program(input int budget, input int fixed_flags);
    int end_cyc;
    bit will_halt;
    for (int i = 0; i < 256; i++)
      fl[i] = (fixed_flags < 0) ? 4'($urandom) : 4'(fixed_flags);
    build_expect(budget, end_cyc, will_halt);
    halt_seen = 0;
    mon_en    = 1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    flags = fl[1];
    while (cyc < end_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      flags = fl[cyc];
    end
    @(negedge clk);
    #1;
    mon_en = 0;
    check(exp_q.size() == 0, "events_drained",
          $sformatf("%0d expected events never seen", exp_q.size()));
    exp_q.delete();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check(control == 16'h0000 && constant_out == 4'h0 && pc_addr == 4'h0 &&
          busy == 1'b0 && halted == 1'b0, "async_reset",
          $sformatf("got ctl=%h k=%h pc=%h busy=%b halted=%b, want all zero",
                    control, constant_out, pc_addr, busy, halted));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (control != 16'h0000 || constant_out != 4'h0) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_exec",
                $sformatf("cycle %0d ctl=%h k=%h, want no output", cyc, control, constant_out));
        end else begin
          e = exp_q.pop_front();
          check(!e.is_halt && e.cyc == cyc && control == e.cw &&
                constant_out == e.k && pc_addr == e.pc && busy, "exec_event",
                $sformatf("got cyc=%0d ctl=%h k=%h pc=%h busy=%b, want halt=%b cyc=%0d ctl=%h k=%h pc=%h",
                          cyc, control, constant_out, pc_addr, busy,
                          e.is_halt, e.cyc, e.cw, e.k, e.pc));
        end
      end
      if (halted && !halt_seen) begin
        halt_seen = 1;
        if (exp_q.size() == 0) begin
          check(0, "unexpected_halt", $sformatf("cycle %0d pc=%h", cyc, pc_addr));
        end else begin
          e = exp_q.pop_front();
          check(e.is_halt && e.cyc == cyc && pc_addr == e.pc && !busy, "halt_event",
                $sformatf("got cyc=%0d pc=%h busy=%b, want halt=%b cyc=%0d pc=%h",
                          cyc, pc_addr, busy, e.is_halt, e.cyc, e.pc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flags = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
    #3;
    check(control == 16'h0000 && pc_addr == 4'h0 && !busy && !halted && constant_out == 4'h0,
          "reset_state", $sformatf("ctl=%h pc=%h busy=%b halted=%b k=%h",
                                   control, pc_addr, busy, halted, constant_out));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check(!busy && pc_addr == 4'h0, "idle_without_start",
          $sformatf("busy=%b pc=%h, want 0 0", busy, pc_addr));
    #1;

    // Single datapath op: cycle-by-cycle view.
    mem[0] = 8'h1A;
    mem[1] = 8'hF0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check(busy && control == 16'h0000 && pc_addr == 4'h0, "c1_fetch",
          $sformatf("busy=%b ctl=%h pc=%h", busy, control, pc_addr));
    @(negedge clk);
    check(busy && control == 16'h0000, "c2_decode",
          $sformatf("busy=%b ctl=%h", busy, control));
    @(negedge clk);
    check(control == 16'h8102 && constant_out == 4'hA, "c3_execute",
          $sformatf("ctl=%h k=%h, want 8102 a", control, constant_out));
    @(negedge clk);
    check(pc_addr == 4'h1 && control == 16'h0000, "c4_pc",
          $sformatf("pc=%h ctl=%h, want 1 0000", pc_addr, control));
    #1;
    do_reset();

    // Reset asserted while in EXECUTE.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check(control == 16'h8102, "pre_reset_exec", $sformatf("ctl=%h, want 8102", control));
    do_reset();

    // Jump: control stays zero, pc lands on the target.
    mem[0] = 8'hE5;
    mem[5] = 8'hF0;
    run_program(10, -1);
    check(pc_addr == 4'h5 && halted, "jmp_target", $sformatf("pc=%h halted=%b, want 5 1", pc_addr, halted));
    do_reset();

    // JZ taken / not taken from latched flags.
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
    mem[0] = 8'h20;
    mem[1] = 8'hD9;
    run_program(20, 1);
    check(pc_addr == 4'h9, "jz_taken", $sformatf("pc=%h, want 9", pc_addr));
    do_reset();
    run_program(20, 0);
    check(pc_addr == 4'h2, "jz_not_taken", $sformatf("pc=%h, want 2", pc_addr));
    do_reset();

    // pc wraps from 15 to 0.
    mem[0]  = 8'hEF;
    mem[15] = 8'h30;
    run_program(6, -1);
    check(pc_addr == 4'h0, "pc_wrap", $sformatf("pc=%h, want 0", pc_addr));
    do_reset();

    // HALT holds through start pulses until reset.
    mem[0] = 8'hF0;
    run_program(6, -1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start = (i % 2 == 0);
      @(negedge clk);
      check(halted && !busy && pc_addr == 4'h0 && control == 16'h0000, "halt_hold",
            $sformatf("i=%0d halted=%b busy=%b pc=%h ctl=%h", i, halted, busy, pc_addr, control));
    end
    start = 1'b0;
    #1;
    do_reset();
    @(negedge clk);
    check(!busy && !halted, "idle_after_halt", $sformatf("busy=%b halted=%b", busy, halted));
    #1;

    // Random programs with random flags.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_program(int'($urandom_range(20, 90)), -1);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  input  1  begin program execution from IDLE.
REQ-004 SHALL have ports: instr  input  8  instruction word from program memory at pc_addr; [7:4] opcode, [3:0] operand.
REQ-005 SHALL have ports: flags  input  4  datapath status; [0]=Z, [1]=C, [2]=N, [3]=V.
REQ-006 SHALL have ports: pc_addr  output  4  program counter, program memory address.
REQ-007 SHALL have ports: control  output  16  datapath control word.
REQ-008 SHALL have ports: constant_out  output  4  immediate operand to datapath constant input.
REQ-009 SHALL have ports: busy  output  1  high in FETCH, DECODE, EXECUTE.
REQ-010 SHALL have ports: halted  output  1  high in HALT.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-012 IDLE: start=1 -> FETCH next edge; start=0 -> stay; start ignored in every other state.
REQ-013 FETCH: pc_addr=pc; at edge ir <= instr; -> DECODE.
REQ-014 DECODE: opcode 0x0-0xB -> pc <= pc+1, -> EXECUTE.
REQ-015 DECODE: 0xE JMP -> pc <= operand, -> FETCH.
REQ-016 DECODE: 0xD JZ -> pc <= operand if flag_reg[0] else pc+1, -> FETCH.
REQ-017 DECODE: 0xC JC -> same as JZ using flag_reg[1].
REQ-018 DECODE: 0xF HALT -> pc unchanged, -> HALT.
REQ-019 EXECUTE: control = CW_TABLE[ir[7:4]], constant_out = ir[3:0] for exactly one cycle; at edge flag_reg <= flags; -> FETCH.
REQ-020 Outside EXECUTE, control SHALL be 16'h0000 (no register write) and constant_out SHALL be 4'h0.
REQ-021 Latency: datapath ops 3 cycles (FETCH, DECODE, EXECUTE); branches/jumps 2 cycles; no pipelining.
REQ-022 pc increment SHALL wrap modulo 16 (4'hF+1 -> 4'h0).
REQ-023 Branches SHALL use flag_reg (flags latched in the last EXECUTE), never live flags; flag_reg=0 before first EXECUTE.
REQ-024 HALT SHALL be left only by rst_n; pc_addr holds the HALT address.
REQ-025 control, constant_out, busy, halted SHALL depend only on registered state and ir (no combinational input-to-output path).

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, pc=0, ir=0, flag_reg=0, control=16'h0000, constant_out=0, busy=0, halted=0, including mid-instruction.
REQ-027 After rst_n release, the first possible state change SHALL occur on the next rising clk edge with start=1.

Structure
REQ-028 Package control_pkg SHALL hold: state enum, opcode constants (OP_JC=4'hC, OP_JZ=4'hD, OP_JMP=4'hE, OP_HALT=4'hF), flag bit indices, CW_TABLE (16 x 16-bit; entries 0xC-0xF = 16'h0000).
REQ-029 Sub-module decodificador_instr SHALL map opcode -> control word via CW_TABLE (combinational); FSM, pc, ir, flag_reg live in unidad_control.

Verification
REQ-030 Reset mid-EXECUTE with instr=8'h1A: rst_n low -> control=16'h0000, pc_addr=0, busy=0 without waiting for clk.
REQ-031 start, mem[0]=8'h1A: FETCH, DECODE, EXECUTE on cycles 1-3; cycle 3 control=CW_TABLE[1], constant_out=4'hA; cycle 4 pc_addr=1.
REQ-032 mem[0]=8'hE5: after 2 cycles pc_addr=5, control stays 16'h0000 throughout.
REQ-033 mem[0]=8'h20 with flags=4'b0001 in EXECUTE, mem[1]=8'hD9 -> pc_addr=9; repeat with flags=4'b0000 -> pc_addr=2.
REQ-034 mem[15]=8'h30, pc=15 -> after EXECUTE pc_addr=0 (wrap).
REQ-035 mem[0]=8'hF0 -> halted=1, busy=0, pc_addr=0 held for 20 cycles; start pulses ignored; rst_n then returns IDLE.
